ccff_bitstream_loader: RTL and testbench
========================================

// Module: ccff_bitstream_loader
// PURPOSE
//  Drives the configuration-chain protocol that routing tiles consume. It sits upstream of a chain of
//  *_mem cells on ccff_head, config_enable and ccff_tail. It accepts configuration words over a
//  valid/ready stream and serialises them into ccff_head, gating each shift with config_enable.
//  An optional verify pass recirculates ccff_tail into ccff_head and checks parity of the loaded bits.
// PARAMETERS
//  CHAIN_LEN  36  number of config flops in the downstream chain (e.g. 9 mux mems x 4 bits)
//  WORD_W     8   width of input config word
// PORTS
//  prog_clk       in   1       programming clock; only clock in the block
//  pReset         in   1       synchronous reset, active-high
//  start          in   1       begin a load; honoured only in IDLE
//  verify_en      in   1       sampled with start; 1 = run the VERIFY pass after LOAD
//  s_data         in   WORD_W  config word; bit 0 is shifted first
//  s_valid        in   1       s_data valid
//  s_ready        out  1       word accepted on a cycle where s_valid & s_ready
//  ccff_head      out  1       serial config data into the chain
//  config_enable  out  1       chain shift enable; chain flops capture on an edge where it is 1
//  ccff_tail      in   1       serial output of the last chain flop
//  busy           out  1       1 in LOAD, GAP or VERIFY
//  done           out  1       one-cycle pulse when an operation completes
//  err            out  1       VERIFY parity mismatch; sticky until the next accepted start
// BEHAVIOUR
//  Reset (pReset=1 at an edge)
//   - state=IDLE; all counters, the word buffer and parity are cleared.
//   - config_enable=0, ccff_head=0, s_ready=0, busy=0, done=0, err=0.
//  FSM: IDLE -> LOAD -> [GAP -> VERIFY] -> DONE -> IDLE.
//  IDLE
//   - start=1: next cycle enter LOAD. Clear err, parity and bit_cnt; latch verify_en.
//  LOAD
//   - Words needed: NW = ceil(CHAIN_LEN/WORD_W).
//   - Word buffer: WORD_W-bit shift register plus a count of bits remaining.
//   - s_ready=1 when words_taken<NW and the buffer is empty or holds exactly 1 bit (back-to-back refill).
//   - Shift cycle (buffer non-empty): the next edge registers ccff_head=buf[0] and config_enable=1,
//     shifts the buffer right, increments bit_cnt and updates parity ^= buf[0].
//   - Stall cycle (buffer empty): the next edge registers config_enable=0; ccff_head holds its value.
//   - Last word: bits at positions >= CHAIN_LEN-(NW-1)*WORD_W are discarded and never shifted.
//   - After CHAIN_LEN shift cycles: s_ready=0.
//     Go to GAP if verify was latched, else to DONE.
//   - Result: the first-shifted bit lands in the flop that drives ccff_tail.
//   - bit_cnt width is $clog2(CHAIN_LEN+1).
//  GAP
//   - Exactly one cycle with config_enable=0, so the final LOAD capture completes before VERIFY starts.
//  VERIFY
//   - Lasts CHAIN_LEN cycles, each with config_enable=1 and ccff_head=ccff_tail (combinational recirculate).
//   - Chain contents are identical after the pass.
//   - Each cycle sample ccff_tail into vparity. At the end set err = (vparity != parity).
//  DONE
//   - done=1 for one cycle, config_enable=0, busy=0; then IDLE.
//  Latency: a load with no stalls takes CHAIN_LEN+2 cycles from start to done. Add CHAIN_LEN+1 for verify.
//  Boundary cases
//   - start while busy or in DONE: ignored.
//   - s_valid outside LOAD, or after NW words: not accepted (s_ready=0).
//   - pReset mid-operation: IDLE on that edge with config_enable=0. No done pulse.
//     Partial chain contents are don't-care.
//   - s_valid deasserted mid-load: stall; chain flops hold because config_enable=0.
//   - CHAIN_LEN a multiple of WORD_W: no bits discarded.
// STRUCTURE
//  - Package ccff_loader_pkg: state enum (IDLE, LOAD, GAP, VERIFY, DONE), an NW localparam function,
//    a cnt_w function.
//  - One sub-module ccff_word_serializer: word buffer, s_ready and bit-pop interface.
//  - Top holds the FSM, counters, parity and output registers.
// TESTING (CHAIN_LEN=36, WORD_W=8, NW=5; bench models a 36-flop chain gated by config_enable)
//  1. Load words 0xA5,0x3C,0xFF,0x00,0x09 back-to-back, verify_en=0.
//     -> 36 enabled shifts; done at cycle 38; chain matches; bits 4..7 of 0x09 unused.
//  2. Same load with s_valid low for 3 cycles after word 2.
//     -> config_enable=0 exactly 3 extra cycles; final chain identical; done 3 cycles later.
//  3. Load with verify_en=1 and an ideal chain.
//     -> one GAP cycle, 36 VERIFY cycles; chain unchanged; done with err=0.
//  4. Verify with the bench flipping chain flop 17 after LOAD.
//     -> err=1 at done; err stays 1 until the next start, then clears.
//  5. pReset asserted at shift 20 of LOAD.
//     -> next cycle IDLE, config_enable=0, s_ready=0, no done pulse; a following full load succeeds.
//  6. start pulsed during LOAD and s_valid held after word 5.
//     -> start ignored; no sixth word accepted; exactly 36 shifts.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain bitstream loader.
// Holds the FSM state encoding plus word-count and counter-width helpers.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    GAP    = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Number of input words needed to cover the whole chain.
  function automatic int nw(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the loader: accepts config words and pops them out one bit per cycle,
// LSB first, trimming the final word so exactly CHAIN_LEN bits are ever presented.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              i_en,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_bit_valid
);
  localparam int NW        = nw(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int CW        = cnt_w(WORD_W);
  localparam int TW        = cnt_w(NW);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORD_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST_BITS);
  localparam logic [TW-1:0] NW_CNT   = TW'(NW);

  logic [WORD_W-1:0] r_buf;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_taken;
  logic              w_pop;
  logic              w_accept;
  logic              w_last_word;

  // Handshake: a word transfers on an edge where i_valid & o_ready; o_ready never depends on i_valid.
  // Ready also with one bit left so the refill lands on the same edge as the last pop.
  assign o_ready     = i_en && (r_taken < NW_CNT) && (r_cnt <= CW'(1));
  assign w_accept    = o_ready && i_valid;
  assign o_bit_valid = (r_cnt != '0);
  assign o_bit       = r_buf[0];
  assign w_pop       = i_en && o_bit_valid;
  assign w_last_word = (r_taken == NW_CNT - TW'(1));

  always_ff @(posedge prog_clk) begin
    if (pReset || i_clear) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_taken <= '0;
    end else if (w_accept) begin
      r_buf   <= i_data;
      r_cnt   <= w_last_word ? LAST_CNT : FULL_CNT;
      r_taken <= r_taken + TW'(1);
    end else if (w_pop) begin
      r_buf <= r_buf >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serialises config words into ccff_head under config_enable and
// optionally recirculates the chain once to compare its parity against what was loaded.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            o_dbg_state
);
  localparam int BW = cnt_w(CHAIN_LEN);
  localparam logic [BW-1:0] LEN_CNT   = BW'(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_VCNT = BW'(CHAIN_LEN - 1);

  state_e        r_state;
  logic          r_verify;
  logic [BW-1:0] r_bit_cnt;
  logic          r_parity;
  logic          r_vparity;
  logic          r_head;
  logic          r_ce;
  logic          r_done;
  logic          r_err;
  logic          w_bit;
  logic          w_bit_valid;

  ccff_word_serializer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_ser (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .i_en       (r_state == LOAD),
    .i_clear    (r_state == IDLE),
    .i_data     (s_data),
    .i_valid    (s_valid),
    .o_ready    (s_ready),
    .o_bit      (w_bit),
    .o_bit_valid(w_bit_valid)
  );

  // During VERIFY the tail feeds straight back so one full pass leaves the chain unchanged.
  assign ccff_head     = (r_state == VERIFY) ? ccff_tail : r_head;
  assign config_enable = r_ce;
  assign busy          = (r_state == LOAD) || (r_state == GAP) || (r_state == VERIFY);
  assign done          = r_done;
  assign err           = r_err;
  assign o_dbg_state   = r_state;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state   <= IDLE;
      r_verify  <= 1'b0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_vparity <= 1'b0;
      r_head    <= 1'b0;
      r_ce      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ce <= 1'b0;
          if (start) begin
            r_state   <= LOAD;
            r_verify  <= verify_en;
            r_err     <= 1'b0;
            r_parity  <= 1'b0;
            r_vparity <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        LOAD: begin
          // The final enabled cycle is still in LOAD so its capture edge closes the load.
          if (r_bit_cnt == LEN_CNT) begin
            r_ce      <= 1'b0;
            r_bit_cnt <= '0;
            if (r_verify) begin
              r_state <= GAP;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else if (w_bit_valid) begin
            r_head    <= w_bit;
            r_ce      <= 1'b1;
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_parity  <= r_parity ^ w_bit;
          end else begin
            r_ce <= 1'b0;
          end
        end
        GAP: begin
          r_ce    <= 1'b1;
          r_state <= VERIFY;
        end
        VERIFY: begin
          r_vparity <= r_vparity ^ ccff_tail;
          r_bit_cnt <= r_bit_cnt + BW'(1);
          if (r_bit_cnt == LAST_VCNT) begin
            r_ce    <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= ((r_vparity ^ ccff_tail) != r_parity);
          end
        end
        DONE: begin
          r_ce    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ce    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: models a 36-flop chain gated by config_enable and
// scoreboards every shifted bit, the final chain image, timing and error reporting.
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  localparam int CHAIN_LEN = 36;
  localparam int WORD_W    = 8;
  localparam int NW        = 5;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int BUDGET    = 200;
  localparam int FLIP_POS  = 17;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic              verify_en;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              config_enable;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              err;
  state_e            dbg_state;

  logic [CHAIN_LEN-1:0] chain;
  logic                 flip_req;
  logic [0:0]           exp_q[$];
  logic [WORD_W-1:0]    words[NW];

  int n_checks = 0;
  int n_fail   = 0;

  bit op_verify, op_stall, op_flip, op_start_mid, op_extra_valid;
  int op_reset_at;

  ccff_bitstream_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .verify_en    (verify_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .o_dbg_state  (dbg_state)
  );

  // clock / chain model
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    else if (flip_req) chain[FLIP_POS] <= ~chain[FLIP_POS];
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input bit v, input bit st, input bit fl, input int rst_at,
                        input bit sm, input bit ev);
    op_verify      = v;
    op_stall       = st;
    op_flip        = fl;
    op_reset_at    = rst_at;
    op_start_mid   = sm;
    op_extra_valid = ev;
  endtask

  // Drives one operation from start, cycle by cycle, and checks it against the chain model.
  task automatic run_op();
    int n, wi, stall_left, ce_ld, ce_vr, first_ce, last_ce, done_cnt, vr_bad, done_n;
    int exp_done_n, exp_gaps, exp_ce_vr;
    bit fin, acc, rst_fired, flipped;
    logic err_at_done;
    logic [0:0] e;
    logic [CHAIN_LEN-1:0] exp_chain;

    for (int k = 0; k < CHAIN_LEN; k++) exp_chain[CHAIN_LEN-1-k] = words[k / WORD_W][k % WORD_W];
    if (op_flip) exp_chain[FLIP_POS] = ~exp_chain[FLIP_POS];
    exp_done_n = CHAIN_LEN + 2 + (op_stall ? 3 : 0) + (op_verify ? CHAIN_LEN + 1 : 0);
    exp_gaps   = op_stall ? 3 : 0;
    exp_ce_vr  = op_verify ? CHAIN_LEN : 0;

    n = -1; wi = 0; stall_left = op_stall ? 3 : 0; ce_ld = 0; ce_vr = 0;
    first_ce = -1; last_ce = -1; done_cnt = 0; vr_bad = 0; done_n = -1;
    fin = 0; acc = 0; rst_fired = 0; flipped = 0; err_at_done = 1'b0;
    exp_q.delete();

    start = 1'b1; verify_en = op_verify; s_valid = 1'b0;
    while (!fin && n < BUDGET) begin
      @(posedge prog_clk); #1; n++;
      flip_req  = 1'b0;
      start     = op_start_mid && (n == 5);
      verify_en = op_verify || start;
      if (acc) begin
        if (wi < NW) begin
          for (int j = 0; j < ((wi == NW - 1) ? LAST_BITS : WORD_W); j++) begin
            e = words[wi][j];
            exp_q.push_back(e);
          end
        end
        wi++;
      end
      if (n == 0) begin
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_clears_err", 64'(err), 64'd0);
      end
      if (rst_fired) begin
        chk("rst_ce", 64'(config_enable), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_no_done", 64'(done_cnt + int'(done)), 64'd0);
        pReset = 1'b0;
        fin = 1;
      end else begin
        if (done) begin
          done_cnt++; done_n = n; err_at_done = err; fin = 1;
        end
        if (config_enable) begin
          if (ce_ld < CHAIN_LEN) begin
            ce_ld++;
            if (first_ce < 0) first_ce = n;
            last_ce = n;
            if (exp_q.size() == 0) chk("sb_depth", 64'(exp_q.size()), 64'd1);
            else begin
              e = exp_q.pop_front();
              chk("sb_head", 64'(ccff_head), 64'(e));
            end
          end else begin
            ce_vr++;
            if (ccff_head !== ccff_tail) vr_bad++;
          end
        end
        if (op_flip && busy && !config_enable && ce_ld == CHAIN_LEN && ce_vr == 0 && !flipped) begin
          flip_req = 1'b1; flipped = 1;
        end
        if (op_reset_at > 0 && ce_ld == op_reset_at) begin
          pReset = 1'b1; rst_fired = 1;
        end
      end
      if (!fin) begin
        if (op_stall && wi == 2 && stall_left > 0) begin
          s_valid = 1'b0;
          if (s_ready) stall_left--;
        end else begin
          s_valid = (wi < NW) || op_extra_valid;
        end
        s_data = (wi < NW) ? words[wi] : WORD_W'($urandom_range(0, 255));
        acc = s_valid && s_ready;
      end
    end
    start = 1'b0; verify_en = 1'b0; s_valid = 1'b0;

    if (op_reset_at > 0) begin
      chk("rst_seen", 64'(rst_fired), 64'd1);
    end else begin
      chk("done_seen", 64'(done_cnt), 64'd1);
      chk("done_cycle", 64'(done_n), 64'(exp_done_n));
      chk("load_shifts", 64'(ce_ld), 64'(CHAIN_LEN));
      chk("verify_shifts", 64'(ce_vr), 64'(exp_ce_vr));
      chk("load_stalls", 64'(last_ce - first_ce + 1 - CHAIN_LEN), 64'(exp_gaps));
      chk("words_taken", 64'(wi), 64'(NW));
      chk("sb_left", 64'(exp_q.size()), 64'd0);
      chk("recirc_head", 64'(vr_bad), 64'd0);
      chk("err_at_done", 64'(err_at_done), 64'(op_flip));
      chk("chain", 64'(chain), 64'(exp_chain));
      @(posedge prog_clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; verify_en = 1'b0; s_valid = 1'b1; s_data = 8'h5A; flip_req = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_ce", 64'(config_enable), 64'd0);
    chk("reset_head", 64'(ccff_head), 64'd0);
    chk("reset_ready", 64'(s_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    pReset = 1'b0;
    repeat (2) begin
      @(posedge prog_clk); #1;
      chk("idle_ready", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;

    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h09};
    set_op(0, 0, 0, 0, 0, 0); run_op();   // plain back-to-back load
    set_op(0, 1, 0, 0, 0, 0); run_op();   // 3-cycle source stall
    set_op(1, 0, 0, 0, 0, 0); run_op();   // verify, ideal chain
    set_op(1, 0, 1, 0, 0, 0); run_op();   // verify with flop 17 flipped
    repeat (3) @(posedge prog_clk);
    #1;
    chk("err_sticky", 64'(err), 64'd1);
    set_op(0, 0, 0, 0, 1, 1); run_op();   // start mid-load, extra valid words
    set_op(0, 0, 0, 20, 0, 0); run_op();  // reset at shift 20
    set_op(0, 0, 0, 0, 0, 0); run_op();   // full load after reset

    for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom_range(0, 255));
    words[NW-1][WORD_W-1] = 1'b1;         // discarded bits set, must never reach the chain
    set_op(1, 0, 0, 0, 0, 0); run_op();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
